// File: rtl/player_move_sched_pkg.sv
// Shared VGA/player constants and the move-scheduler state type.
package player_move_sched_pkg;

  localparam int HOR_PIXELS   = 1024;
  localparam int VER_PIXELS   = 768;
  localparam int PLAYER_SIZE  = 15;

  // First line of vertical blanking in 1024x768 timing.
  localparam int VBLANK_START = VER_PIXELS;

  localparam int PLAYER_X_MAX  = HOR_PIXELS - PLAYER_SIZE;        // 1009
  localparam int PLAYER_Y_MAX  = VER_PIXELS - PLAYER_SIZE;        // 753
  localparam int PLAYER_X_INIT = (HOR_PIXELS - PLAYER_SIZE) / 2;  // 504
  localparam int PLAYER_Y_INIT = (VER_PIXELS - PLAYER_SIZE) / 2;  // 376

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_APPLY,
    ST_ACK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/player_move_sched_if.sv
// Move-request handshake bundle between requesters and the scheduler.
interface player_move_sched_if #(
  parameter int N_REQ  = 2,
  parameter int STEP_W = 5
) ();
  logic [N_REQ-1:0]        req;
  logic [N_REQ*STEP_W-1:0] dx;
  logic [N_REQ*STEP_W-1:0] dy;
  logic [N_REQ-1:0]        ack;

  modport master (output req, output dx, output dy, input  ack);
  modport slave  (input  req, input  dx, input  dy, output ack);
endinterface

// File: rtl/pos_clamp.sv
// Adds a signed step to an on-screen coordinate, saturating to [0, max_i].
module pos_clamp #(
  parameter int STEP_W = 5
) (
  input  logic [10:0]        coord_i,
  input  logic [STEP_W-1:0]  delta_i,
  input  logic [10:0]        max_i,
  output logic [10:0]        coord_o
);

  logic [11:0] sum;

  // 12-bit two's complement sum; bit 11 set means the result went negative.
  always_comb begin
    sum = {1'b0, coord_i} + {{(12-STEP_W){delta_i[STEP_W-1]}}, delta_i};
    if (sum[11]) begin
      coord_o = '0;
    end else if (sum[10:0] > max_i) begin
      coord_o = max_i;
    end else begin
      coord_o = sum[10:0];
    end
  end

endmodule

// File: rtl/player_move_sched.sv
// Frame-synchronous round-robin scheduler for player position updates.
// Positions only move during the service pass launched at vblank start.
module player_move_sched
  import player_move_sched_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int STEP_W = 5,
  parameter int X_INIT = PLAYER_X_INIT,
  parameter int Y_INIT = PLAYER_Y_INIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         vcount,
  input  logic [10:0]         hcount,
  player_move_sched_if.slave  mv,
  output logic [10:0]         player_x,
  output logic [10:0]         player_y,
  output logic                frame_tick,
  output logic                busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SRV_W = $clog2(N_REQ + 1);
  localparam logic [10:0] X_MAX = 11'(PLAYER_X_MAX);
  localparam logic [10:0] Y_MAX = 11'(PLAYER_Y_MAX);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SRV_W-1:0]    served_q, served_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [STEP_W-1:0]   dx_q, dx_d;
  logic [STEP_W-1:0]   dy_q, dy_d;
  logic [10:0]         x_q, x_d;
  logic [10:0]         y_q, y_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                tick_q, tick_d;
  logic                ev_q;
  logic [10:0]         x_new, y_new;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  pos_clamp #(.STEP_W(STEP_W)) u_clamp_x (
    .coord_i (x_q),
    .delta_i (dx_q),
    .max_i   (X_MAX),
    .coord_o (x_new)
  );

  pos_clamp #(.STEP_W(STEP_W)) u_clamp_y (
    .coord_i (y_q),
    .delta_i (dy_q),
    .max_i   (Y_MAX),
    .coord_o (y_new)
  );

  // Register the vblank-start frame event for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= 1'b0;
    end else begin
      ev_q <= (vcount == 11'(VBLANK_START)) && (hcount == '0);
    end
  end

  // State, arbitration pointers, captured deltas and committed position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      served_q <= '0;
      rr_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      x_q      <= 11'(X_INIT);
      y_q      <= 11'(Y_INIT);
      ack_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      served_q <= served_d;
      rr_q     <= rr_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
    end
  end

  // Next-state logic; ack/tick are registered so the position leads ack by a cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    served_d = served_q;
    rr_d     = rr_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    ack_d    = '0;
    tick_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_q) begin
          state_d  = ST_ARB;
          idx_d    = rr_q;
          served_d = '0;
        end
      end
      ST_ARB: begin
        if (served_q == SRV_W'(N_REQ)) begin
          state_d = ST_DONE;
        end else if (mv.req[idx_q]) begin
          dx_d    = mv.dx[idx_q*STEP_W +: STEP_W];
          dy_d    = mv.dy[idx_q*STEP_W +: STEP_W];
          state_d = ST_APPLY;
        end else begin
          idx_d    = inc_idx(idx_q);
          served_d = served_q + 1'b1;
        end
      end
      ST_APPLY: begin
        x_d     = x_new;
        y_d     = y_new;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ack_d[idx_q] = 1'b1;
        idx_d        = inc_idx(idx_q);
        served_d     = served_q + 1'b1;
        state_d      = ST_ARB;
      end
      ST_DONE: begin
        tick_d  = 1'b1;
        rr_d    = inc_idx(rr_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mv.ack     = ack_q;
  assign player_x   = x_q;
  assign player_y   = y_q;
  assign frame_tick = tick_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
